// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM access controller.
package mem_access_ctrl_pkg;

  localparam int DATA_BUS     = 16;
  localparam int REG_ADDR_BUS = 4;
  localparam int RAM_ADDR_BUS = 18;

  // SRAM strobes are active low; this is their idle level.
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ADDR  = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ADDR  = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_HOLD  = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  typedef struct packed {
    logic                    we;
    logic                    reg_we;
    logic [REG_ADDR_BUS-1:0] wb_addr;
    logic [DATA_BUS-1:0]     wdata;
  } hold_t;

  // Wait states always occupy at least one cycle in their FSM state.
  function automatic int wait_cycles(input int w);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_sram_tri_buf.sv
// SRAM data-bus tri-state driver plus the registered read-data sample.
module sram_tri_buf
  import mem_access_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                drive_en,
  input  logic [DATA_BUS-1:0] wdata,
  input  logic                sample_en,
  output logic [DATA_BUS-1:0] rdata,
  inout  wire  [DATA_BUS-1:0] ram_data
);

  logic [DATA_BUS-1:0] rdata_d, rdata_q;

  assign ram_data = drive_en ? wdata : {DATA_BUS{1'bz}};
  assign rdata    = rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (sample_en) rdata_d = ram_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns EXE/MEM memory requests into timed async-SRAM
// accesses and stalls the pipe meanwhile. MEM_ACCESS_STALL_CNT_EN adds counters.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int         RD_WAIT = 1,
  parameter int         WR_WAIT = 1,
  parameter logic [1:0] ADDR_HI = 2'b00
) (
  input  logic                    clk_50MHz,
  input  logic                    rst,
  input  logic                    em_mem_en,
  input  logic                    em_mem_we,
  input  logic [DATA_BUS-1:0]     em_addr,
  input  logic [DATA_BUS-1:0]     em_wdata,
  input  logic [DATA_BUS-1:0]     em_alu_data,
  input  logic                    em_reg_we,
  input  logic [REG_ADDR_BUS-1:0] em_wb_addr,
  output logic                    stall,
  output logic                    mw_reg_we,
  output logic [REG_ADDR_BUS-1:0] mw_wb_addr,
  output logic [DATA_BUS-1:0]     mw_wb_data,
  output logic [RAM_ADDR_BUS-1:0] ram_addr,
  inout  wire  [DATA_BUS-1:0]     ram_data,
  output logic                    ram_ce_n,
  output logic                    ram_oe_n,
  output logic                    ram_we_n
`ifdef MEM_ACCESS_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [15:0]             access_cnt
`endif
);

  localparam logic [2:0] RD_CNT = 3'(wait_cycles(RD_WAIT) - 1);
  localparam logic [2:0] WR_CNT = 3'(wait_cycles(WR_WAIT) - 1);

  state_e                  state_d, state_q;
  logic [2:0]              cnt_d, cnt_q;
  hold_t                   hold_d, hold_q;
  logic [RAM_ADDR_BUS-1:0] ram_addr_d, ram_addr_q;
  logic                    ce_n_d, ce_n_q, oe_n_d, oe_n_q, we_n_d, we_n_q;
  logic                    drive_d, drive_q;
  logic                    mw_reg_we_d, mw_reg_we_q;
  logic [REG_ADDR_BUS-1:0] mw_wb_addr_d, mw_wb_addr_q;
  logic [DATA_BUS-1:0]     mw_wb_data_d, mw_wb_data_q;
  logic                    sample_en;
  logic [DATA_BUS-1:0]     rdata;

  assign stall = ((state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                 ((state_q == ST_IDLE) && em_mem_en);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    ram_addr_d   = ram_addr_q;
    sample_en    = 1'b0;
    mw_reg_we_d  = 1'b0;
    mw_wb_addr_d = mw_wb_addr_q;
    mw_wb_data_d = mw_wb_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (em_mem_en) begin
          hold_d.we      = em_mem_we;
          hold_d.reg_we  = em_reg_we;
          hold_d.wb_addr = em_wb_addr;
          hold_d.wdata   = em_wdata;
          ram_addr_d     = {ADDR_HI, em_addr};
          state_d        = em_mem_we ? ST_WR_ADDR : ST_RD_ADDR;
        end else begin
          mw_reg_we_d  = em_reg_we;
          mw_wb_addr_d = em_wb_addr;
          mw_wb_data_d = em_alu_data;
        end
      end
      ST_RD_ADDR: begin
        state_d = ST_RD_WAIT;
        cnt_d   = RD_CNT;
      end
      ST_RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          sample_en = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_WR_ADDR: begin
        state_d = ST_WR_PULSE;
        cnt_d   = WR_CNT;
      end
      ST_WR_PULSE: begin
        if (cnt_q == 3'd0) state_d = ST_WR_HOLD;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_WR_HOLD: state_d = ST_DONE;
      ST_DONE: begin
        // Only the DONE edge writes back, so a stalled entry retires exactly once.
        state_d      = ST_IDLE;
        mw_reg_we_d  = hold_q.reg_we & ~hold_q.we;
        mw_wb_addr_d = hold_q.wb_addr;
        if (!hold_q.we) mw_wb_data_d = rdata;
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes follow the next state so they are registered in lockstep with it.
    ce_n_d  = STROBE_OFF;
    oe_n_d  = STROBE_OFF;
    we_n_d  = STROBE_OFF;
    drive_d = 1'b0;
    unique case (state_d)
      ST_RD_ADDR, ST_RD_WAIT: begin
        ce_n_d = ~STROBE_OFF;
        oe_n_d = ~STROBE_OFF;
      end
      ST_WR_ADDR, ST_WR_HOLD: begin
        ce_n_d  = ~STROBE_OFF;
        drive_d = 1'b1;
      end
      ST_WR_PULSE: begin
        ce_n_d  = ~STROBE_OFF;
        we_n_d  = ~STROBE_OFF;
        drive_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      ram_addr_q   <= '0;
      ce_n_q       <= STROBE_OFF;
      oe_n_q       <= STROBE_OFF;
      we_n_q       <= STROBE_OFF;
      drive_q      <= 1'b0;
      mw_reg_we_q  <= 1'b0;
      mw_wb_addr_q <= '0;
      mw_wb_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      ram_addr_q   <= ram_addr_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      drive_q      <= drive_d;
      mw_reg_we_q  <= mw_reg_we_d;
      mw_wb_addr_q <= mw_wb_addr_d;
      mw_wb_data_q <= mw_wb_data_d;
    end
  end

  assign ram_ce_n   = ce_n_q;
  assign ram_oe_n   = oe_n_q;
  assign ram_we_n   = we_n_q;
  assign ram_addr   = ram_addr_q;
  assign mw_reg_we  = mw_reg_we_q;
  assign mw_wb_addr = mw_wb_addr_q;
  assign mw_wb_data = mw_wb_data_q;

  sram_tri_buf u_tri_buf (
    .clk       (clk_50MHz),
    .rst       (rst),
    .drive_en  (drive_q),
    .wdata     (hold_q.wdata),
    .sample_en (sample_en),
    .rdata     (rdata),
    .ram_data  (ram_data)
  );

`ifdef MEM_ACCESS_STALL_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [15:0] access_cnt_d, access_cnt_q;

  always_comb begin
    stall_cnt_d  = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    access_cnt_d = (state_q == ST_DONE) ? access_cnt_q + 16'd1 : access_cnt_q;
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      access_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      access_cnt_q <= access_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign access_cnt = access_cnt_q;
`endif

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register outputs.
- Turns each registered memory request into a timed access on the off-chip async SRAM. Non-memory instructions pass through.
- Holds the pipeline with `stall` while an access is in flight, then launches the MEM/WB payload.
- Sits between the EXE/MEM register and the MEM/WB register; it is the only SRAM bus master in the data path.

Parameters:
- RD_WAIT, 1, extra cycles between driving address/OE and sampling read data (0..7).
- WR_WAIT, 1, cycles WE_n is held low (1..7).
- ADDR_HI, 2'b00, constant upper two bits of the 18-bit SRAM address.

Ports:
- clk_50MHz  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- em_mem_en  in  1  current EXE/MEM entry accesses memory
- em_mem_we  in  1  1 = store, 0 = load (valid when em_mem_en)
- em_addr  in  16  word address (ALU result)
- em_wdata  in  16  store data
- em_alu_data  in  16  ALU result for non-load writeback
- em_reg_we  in  1  entry writes the register file
- em_wb_addr  in  4  destination register
- stall  out  1  hold PC/IF/ID/EXE and the EXE/MEM register
- mw_reg_we  out  1  MEM/WB register-write enable
- mw_wb_addr  out  4  MEM/WB destination
- mw_wb_data  out  16  load data or ALU data
- ram_addr  out  18  {ADDR_HI, em_addr}
- ram_data  inout  16  SRAM data bus; Z unless writing
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes

Behaviour:
- Reset, asynchronous, rst=1:
  - state=IDLE, stall=0.
  - mw_reg_we=0, mw_wb_addr=0, mw_wb_data=0.
  - ram_ce_n=ram_oe_n=ram_we_n=1, ram_addr=0, data bus Z.
- Reset mid-access: strobes deassert immediately (asynchronously), the access is abandoned and no writeback is issued.
- States: IDLE, RD_ADDR, RD_WAIT, WR_ADDR, WR_PULSE, WR_HOLD, DONE.
- IDLE with em_mem_en=0:
  - Next edge: mw_reg_we=em_reg_we, mw_wb_addr=em_wb_addr, mw_wb_data=em_alu_data.
  - Latency 1 cycle, no stall.
- IDLE with em_mem_en=1:
  - stall asserts combinationally the same cycle.
  - Registers a copy of addr, wdata, wb_addr, reg_we and we.
  - Goes to RD_ADDR (we=0) or WR_ADDR (we=1).
- Load path:
  - RD_ADDR: ce_n=0, oe_n=0, address driven.
  - RD_WAIT: counts RD_WAIT cycles. When the count expires, it samples ram_data into the hold register and goes to DONE.
  - With RD_WAIT=0, the FSM passes through RD_WAIT for one cycle and samples immediately.
  - Total 3+RD_WAIT cycles, IDLE to IDLE.
- Store path:
  - WR_ADDR: ce_n=0, address and data driven, we_n=1 (setup).
  - WR_PULSE: we_n=0 for WR_WAIT cycles.
  - WR_HOLD: we_n=1 with address and data still driven for 1 cycle, then DONE.
- DONE:
  - stall=0.
  - Next edge: mw_* updated from the hold copy. Loads take data from the sampled register; stores get mw_reg_we=0.
  - Returns to IDLE; the EXE/MEM register advances on the same edge.
- stall: high in every state except IDLE and DONE, and also high in IDLE when em_mem_en=1.
- Back-to-back memory ops: DONE→IDLE, and a new access starts in the IDLE cycle with no bubble dropped or duplicated.
- While stall=1, em_* inputs are ignored; the hold copy is authoritative.
- ram_data is driven only in WR_ADDR, WR_PULSE and WR_HOLD. Outside those states ram_oe_n must be 0 only in RD_ADDR and RD_WAIT, so there is never bus contention.
- Address wrap: the 16-bit address is used as-is with no bounds check.

Optional Feature:
- Macro MEM_ACCESS_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [31:0]: increments every cycle stall=1, wraps at 2^32-1→0, reset to 0.
  - Adds output access_cnt [15:0]: increments on every DONE→IDLE transition.
- When undefined: ports and counters are absent, with no other behavioural change.

Decomposition:
- Shared define file (`define.v` style include guard) holds:
  - FSM state encodings (3-bit).
  - Bus widths: DATA_BUS 16, REG_ADDR_BUS 4, RAM_ADDR_BUS 18.
  - Strobe inactive levels.
- One sub-module, sram_tri_buf: owns the ram_data tri-state driver and the registered input sample.

Test Plan:
- Pass-through: em_mem_en=0, em_alu_data=16'h1234, em_reg_we=1, em_wb_addr=3 → next edge mw_wb_data=1234, mw_wb_addr=3, mw_reg_we=1; stall never high.
- Load, RD_WAIT=1:
  - Model returns 16'hBEEF at addr 16'h0040 → ram_addr=18'h00040.
  - oe_n low for 2 cycles, stall high 3 cycles (IDLE, RD_ADDR, RD_WAIT), then DONE.
  - mw_wb_data=BEEF one edge after DONE.
- Store, WR_WAIT=2: em_wdata=16'hA5A5 at addr 16'h0100 → we_n low exactly 2 cycles; data stable from WR_ADDR through WR_HOLD; memory[0x100]=A5A5; mw_reg_we=0.
- Back-to-back: store 0x0010←0x1111, then load 0x0010 → load returns 1111; bus is Z between the two accesses; no duplicate writeback.
- Reset mid-store: assert rst during WR_PULSE → we_n=1 and ram_data=Z asynchronously; mw_reg_we=0; memory untouched or fully written, never X.
- With MEM_ACCESS_STALL_CNT_EN, after the load and store cases above → stall_cnt=8, access_cnt=2.
